// File: rtl/cla_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder; request-to-response latency 2 cycles.
// rsp_ready low stalls stage 2, then stage 1, then req_ready; CLA_ARB_OVF_EN adds the registered rsp_ovf port.
module cla_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   input  logic [NUM_REQ-1:0]     req_cin,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_sum,
   output logic                   rsp_cout
`ifdef CLA_ARB_OVF_EN
   ,
   output logic                   rsp_ovf
`endif
);

   typedef struct packed {
      logic [31:0]     a;
      logic [31:0]     b;
      logic            cin;
      logic [ID_W-1:0] id;
   } op_t;

   typedef struct packed {
      logic [31:0]     sum;
      logic            cout;
`ifdef CLA_ARB_OVF_EN
      logic            ovf;
`endif
      logic [ID_W-1:0] id;
   } res_t;

   // Carries into bits 0..3 of a 4-wide lookahead block.
   function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p, input logic ci);
      logic [3:0] c;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   function automatic logic [1:0] gen_prop4(input logic [3:0] g, input logic [3:0] p);
      logic gg;
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return {gg, &p};
   endfunction

   op_t               op_q, op_d;
   logic              op_vld_q, op_vld_d;
   res_t              res_q, res_d;
   logic              res_vld_q, res_vld_d;
   logic [ID_W-1:0]   last_q, last_d;

   logic              adv2;
   logic              accept;
   logic              hs;
   logic              rsp_hs;
   logic              grant_vld;
   logic [ID_W-1:0]   grant_idx;
   logic [ID_W-1:0]   cand;
   logic [NUM_REQ-1:0] grant_oh;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;
   logic              sel_cin;

   logic [31:0]       bit_g, bit_p, bit_c;
   logic [7:0]        grp_g, grp_p, grp_c;
   logic [1:0]        sup_g, sup_p, sup_c;
   logic [31:0]       cla_sum;
   logic              cla_cout;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      grant_oh  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((int'(last_q) + k) % NUM_REQ);
         if (!grant_vld && req_valid[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_vld) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_cin = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == ID_W'(i)) begin
            sel_a   = req_a[32*i +: 32];
            sel_b   = req_b[32*i +: 32];
            sel_cin = req_cin[i];
         end
      end
   end

   assign adv2      = op_vld_q && (!res_vld_q || rsp_ready);
   assign accept    = !op_vld_q || adv2;
   assign req_ready = (accept && rst_n) ? grant_oh : '0;
   assign hs        = |(req_valid & req_ready);
   assign rsp_hs    = res_vld_q && rsp_ready;

   // Two-level lookahead: 4-bit groups, then two super-groups of four groups.
   always_comb begin
      bit_g = op_q.a & op_q.b;
      bit_p = op_q.a ^ op_q.b;
      bit_c = '0;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      sup_g = '0;
      sup_p = '0;
      sup_c = '0;
      for (int j = 0; j < 8; j++) begin
         {grp_g[j], grp_p[j]} = gen_prop4(bit_g[4*j +: 4], bit_p[4*j +: 4]);
      end
      for (int s = 0; s < 2; s++) begin
         {sup_g[s], sup_p[s]} = gen_prop4(grp_g[4*s +: 4], grp_p[4*s +: 4]);
      end
      sup_c[0] = op_q.cin;
      sup_c[1] = sup_g[0] | (sup_p[0] & op_q.cin);
      cla_cout = sup_g[1] | (sup_p[1] & sup_c[1]);
      for (int s = 0; s < 2; s++) begin
         grp_c[4*s +: 4] = carries4(grp_g[4*s +: 4], grp_p[4*s +: 4], sup_c[s]);
      end
      for (int j = 0; j < 8; j++) begin
         bit_c[4*j +: 4] = carries4(bit_g[4*j +: 4], bit_p[4*j +: 4], grp_c[j]);
      end
      cla_sum = bit_p ^ bit_c;
   end

   always_comb begin
      op_vld_d  = op_vld_q;
      op_d      = op_q;
      res_vld_d = res_vld_q;
      res_d     = res_q;
      last_d    = last_q;

      if (accept) begin
         op_vld_d = hs;
         if (hs) begin
            op_d.a   = sel_a;
            op_d.b   = sel_b;
            op_d.cin = sel_cin;
            op_d.id  = grant_idx;
         end
      end

      if (hs) begin
         last_d = grant_idx;
      end

      if (adv2) begin
         res_vld_d  = 1'b1;
         res_d.sum  = cla_sum;
         res_d.cout = cla_cout;
         res_d.id   = op_q.id;
`ifdef CLA_ARB_OVF_EN
         res_d.ovf  = (op_q.a[31] == op_q.b[31]) && (cla_sum[31] != op_q.a[31]);
`endif
      end else if (rsp_hs) begin
         res_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_vld_q  <= 1'b0;
         op_q      <= '0;
         res_vld_q <= 1'b0;
         res_q     <= '0;
         last_q    <= ID_W'(NUM_REQ - 1);
      end else begin
         op_vld_q  <= op_vld_d;
         op_q      <= op_d;
         res_vld_q <= res_vld_d;
         res_q     <= res_d;
         last_q    <= last_d;
      end
   end

   assign rsp_valid = res_vld_q;
   assign rsp_id    = res_q.id;
   assign rsp_sum   = res_q.sum;
   assign rsp_cout  = res_q.cout;
`ifdef CLA_ARB_OVF_EN
   assign rsp_ovf   = res_q.ovf;
`endif

endmodule

// File: tb/tb_cla_arbiter.sv
// Scoreboard bench for cla_arbiter: per-requester stimulus queues, round-robin reference and in-order response checks.
module tb_cla_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
   } op_t;

   typedef struct packed {
      logic [IW-1:0] id;
      logic [31:0]   sum;
      logic          cout;
      logic          ovf;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic [N-1:0]      req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_cout;
`ifdef CLA_ARB_OVF_EN
   logic              rsp_ovf;
`endif

   op_t    stim_q[N][$];
   exp_t   exp_q[$];
   int     n_vec = 0;
   int     n_err = 0;
   int     rsp_cnt = 0;
   int     acc_cnt = 0;
   int     model_last = N - 1;
   logic [N-1:0] hs_mask = '0;
   logic          hold_vld = 1'b0;
   logic [IW-1:0] hold_id;
   logic [31:0]   hold_sum;
   logic          hold_cout;
   logic [31:0]   last_sum = '0;
   logic          last_cout = 1'b0;
   logic          last_ovf = 1'b0;

   cla_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout)
`ifdef CLA_ARB_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t model(input op_t o, input int id);
      exp_t e;
      logic [32:0] s;
      s = {1'b0, o.a} + {1'b0, o.b} + {32'd0, o.cin};
      e.id   = IW'(id);
      e.sum  = s[31:0];
      e.cout = s[32];
      e.ovf  = (o.a[31] == o.b[31]) && (s[31] != o.a[31]);
      return e;
   endfunction

   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      logic [IW-1:0] c;
      for (int k = 1; k <= N; k++) begin
         c = IW'((last + k) % N);
         if (v[c]) return int'(c);
      end
      return -1;
   endfunction

   function automatic bit idle();
      for (int i = 0; i < N; i++) begin
         if (stim_q[i].size() != 0) return 1'b0;
      end
      return (exp_q.size() == 0) && (rsp_valid === 1'b0);
   endfunction

   // Requesters: present queue head, hold it until the handshake seen on the previous falling edge.
   initial begin
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (rst_n && hs_mask[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
            if (stim_q[i].size() > 0) begin
               req_valid[i]        = 1'b1;
               req_a[32*i +: 32]   = stim_q[i][0].a;
               req_b[32*i +: 32]   = stim_q[i][0].b;
               req_cin[i]          = stim_q[i][0].cin;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // Monitor: grant order against the round-robin reference, response scoreboard, hold stability.
   initial begin
      int          pick;
      logic [N-1:0] exp_oh;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hs_mask  = '0;
            hold_vld = 1'b0;
         end else begin
            pick = rr_pick(model_last, req_valid);
            if (req_ready !== '0) begin
               n_vec++;
               exp_oh = '0;
               if (pick >= 0) exp_oh[pick[IW-1:0]] = 1'b1;
               if (req_ready !== exp_oh) begin
                  n_err++;
                  $display("FAIL rr_grant: req_ready=%b expected %b (req_valid=%b)", req_ready, exp_oh, req_valid);
               end
               if (pick >= 0 && stim_q[pick].size() > 0) begin
                  exp_q.push_back(model(stim_q[pick][0], pick));
                  model_last = pick;
                  acc_cnt++;
               end
               hs_mask = req_ready & req_valid;
            end else begin
               hs_mask = '0;
            end

            if (hold_vld) begin
               n_vec++;
               if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, hold_id, hold_sum, hold_cout}) begin
                  n_err++;
                  $display("FAIL rsp_stable: got v=%b id=%0d sum=%h c=%b, held id=%0d sum=%h c=%b",
                           rsp_valid, rsp_id, rsp_sum, rsp_cout, hold_id, hold_sum, hold_cout);
               end
            end

            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
               rsp_cnt++;
               n_vec++;
               last_sum  = rsp_sum;
               last_cout = rsp_cout;
`ifdef CLA_ARB_OVF_EN
               last_ovf  = rsp_ovf;
`endif
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL rsp_unexpected: id=%0d sum=%h with nothing outstanding", rsp_id, rsp_sum);
               end else begin
                  e = exp_q.pop_front();
`ifdef CLA_ARB_OVF_EN
                  if ({rsp_id, rsp_sum, rsp_cout, rsp_ovf} !== {e.id, e.sum, e.cout, e.ovf}) begin
                     n_err++;
                     $display("FAIL rsp_data: got id=%0d sum=%h c=%b ovf=%b, expected id=%0d sum=%h c=%b ovf=%b",
                              rsp_id, rsp_sum, rsp_cout, rsp_ovf, e.id, e.sum, e.cout, e.ovf);
                  end
`else
                  if ({rsp_id, rsp_sum, rsp_cout} !== {e.id, e.sum, e.cout}) begin
                     n_err++;
                     $display("FAIL rsp_data: got id=%0d sum=%h c=%b, expected id=%0d sum=%h c=%b",
                              rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout);
                  end
`endif
               end
            end

            hold_vld  = (rsp_valid === 1'b1) && (rsp_ready === 1'b0);
            hold_id   = rsp_id;
            hold_sum  = rsp_sum;
            hold_cout = rsp_cout;
         end
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic samp();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int r, input logic [31:0] a, input logic [31:0] b, input logic cin);
      op_t o;
      o.a   = a;
      o.b   = b;
      o.cin = cin;
      stim_q[r].push_back(o);
   endtask

   task automatic drain(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         samp();
         if (idle()) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      push(3, 32'h0000_0010, 32'h0000_0020, 1'b0);
      samp();
      samp();
      n_vec++;
      if (req_ready !== '0) begin
         n_err++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
      end
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
      end
      n_vec++;
      if ({rsp_id, rsp_sum, rsp_cout} !== '0) begin
         n_err++; $display("FAIL reset_rsp_data: got id=%0d sum=%h c=%b expected zeros", rsp_id, rsp_sum, rsp_cout);
      end
`ifdef CLA_ARB_OVF_EN
      n_vec++;
      if (rsp_ovf !== 1'b0) begin
         n_err++; $display("FAIL reset_rsp_ovf: got %b expected 0", rsp_ovf);
      end
`endif
      drive_edge();
      rst_n = 1'b1;
      samp();
      n_vec++;
      if (req_ready !== 4'b1000) begin
         n_err++; $display("FAIL reset_first_grant: req_ready=%b expected 1000", req_ready);
      end
      drain(20, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL reset_drain: timeout, %0d responses outstanding", exp_q.size());
      end
   endtask

   task automatic test_single_add();
      bit ok;
      bit seen;
      push(0, 32'h0000_0001, 32'h0000_0001, 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         samp();
         if (req_ready[0] === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL single_grant: req_ready[0] never 1, expected within 10 cycles");
      end
      samp();
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++; $display("FAIL single_latency_early: rsp_valid=%b one cycle after handshake, expected 0", rsp_valid);
      end
      samp();
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 32'h0000_0003, 1'b0}) begin
         n_err++;
         $display("FAIL single_rsp: got v=%b id=%0d sum=%h c=%b expected v=1 id=0 sum=00000003 c=0",
                  rsp_valid, rsp_id, rsp_sum, rsp_cout);
      end
      drain(20, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL single_drain: timeout");
      end
   endtask

   task automatic test_fairness();
      bit ok;
      bit seen;
      int start;
      for (int rep = 0; rep < 3; rep++) begin
         for (int r = 0; r < N; r++) begin
            push(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
         end
      end
      start = rsp_cnt;
      seen  = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         samp();
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_err++; $display("FAIL fair_first_rsp: no response within 20 cycles");
      end
      repeat (11) samp();
      n_vec++;
      if (rsp_cnt - start != 12) begin
         n_err++; $display("FAIL fair_throughput: %0d responses in 12 cycles, expected 12", rsp_cnt - start);
      end
      drain(30, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL fair_drain: timeout");
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      int   a0;
      exp_t e1;
      op_t  o1;
      drive_edge();
      rsp_ready = 1'b0;
      a0 = acc_cnt;
      o1.a = 32'h1234_5678; o1.b = 32'h0F0F_0F0F; o1.cin = 1'b1;
      e1 = model(o1, 1);
      push(1, o1.a, o1.b, o1.cin);
      push(2, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
      push(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
      repeat (5) samp();
      n_vec++;
      if (acc_cnt - a0 != 2) begin
         n_err++; $display("FAIL bp_accepts: %0d accepted while stalled, expected 2", acc_cnt - a0);
      end
      n_vec++;
      if (req_ready !== '0 || req_valid[1] !== 1'b1) begin
         n_err++; $display("FAIL bp_req_ready: req_ready=%b req_valid=%b, expected ready 0000 with req 1 pending", req_ready, req_valid);
      end
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, e1.id, e1.sum, e1.cout}) begin
         n_err++;
         $display("FAIL bp_held_rsp: got v=%b id=%0d sum=%h c=%b expected v=1 id=1 sum=%h c=%b",
                  rsp_valid, rsp_id, rsp_sum, rsp_cout, e1.sum, e1.cout);
      end
      drive_edge();
      rsp_ready = 1'b1;
      drain(30, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL bp_drain: timeout");
      end
   endtask

   task automatic test_carry();
      bit ok;
      bit done;
      logic [31:0] a;
      logic [31:0] b;
      push(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      drain(20, ok);
      n_vec++;
      if (!ok || {last_cout, last_sum} !== {1'b1, 32'h0000_0000}) begin
         n_err++; $display("FAIL carry_msb: got sum=%h c=%b expected sum=00000000 c=1", last_sum, last_cout);
      end
      push(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      drain(20, ok);
      n_vec++;
      if (!ok || {last_cout, last_sum} !== {1'b1, 32'h0000_0000}) begin
         n_err++; $display("FAIL carry_ripple: got sum=%h c=%b expected sum=00000000 c=1", last_sum, last_cout);
      end
      for (int k = 0; k < 24; k++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
         push($urandom_range(0, N - 1), a, b, 1'($urandom_range(0, 1)));
      end
      done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         drive_edge();
         rsp_ready = 1'($urandom_range(0, 1));
         if (idle()) done = 1'b1;
      end
      drive_edge();
      rsp_ready = 1'b1;
      drain(40, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL random_drain: timeout, %0d outstanding", exp_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      bit ok;
      bit seen;
      drive_edge();
      rsp_ready = 1'b0;
      push(1, 32'h0000_0100, 32'h0000_0200, 1'b0);
      push(2, 32'h0000_0300, 32'h0000_0400, 1'b0);
      push(3, 32'h0000_0500, 32'h0000_0600, 1'b1);
      repeat (4) samp();
      n_vec++;
      if (rsp_valid !== 1'b1) begin
         n_err++; $display("FAIL midrst_pre: rsp_valid=%b expected 1 before reset", rsp_valid);
      end
      drive_edge();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (rsp_valid !== 1'b0 || req_ready !== '0) begin
         n_err++; $display("FAIL midrst_async: rsp_valid=%b req_ready=%b expected 0 and 0000", rsp_valid, req_ready);
      end
      exp_q.delete();
      model_last = N - 1;
      push(0, 32'h0000_0007, 32'h0000_0008, 1'b0);
      samp();
      samp();
      drive_edge();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         samp();
         if (req_ready !== '0) seen = 1'b1;
      end
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++; $display("FAIL midrst_first_grant: req_ready=%b expected 0001", req_ready);
      end
      drain(30, ok);
      n_vec++;
      if (!ok) begin
         n_err++; $display("FAIL midrst_drain: timeout");
      end
   endtask

`ifdef CLA_ARB_OVF_EN
   task automatic test_ovf();
      bit ok;
      push(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      drain(20, ok);
      n_vec++;
      if (!ok || {last_ovf, last_sum} !== {1'b1, 32'h8000_0000}) begin
         n_err++; $display("FAIL ovf_pos: got ovf=%b sum=%h expected ovf=1 sum=80000000", last_ovf, last_sum);
      end
      push(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      drain(20, ok);
      n_vec++;
      if (!ok || last_ovf !== 1'b0) begin
         n_err++; $display("FAIL ovf_neg: got ovf=%b expected 0", last_ovf);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      test_reset();
      test_single_add();
      test_fairness();
      test_backpressure();
      test_carry();
      test_reset_midflight();
`ifdef CLA_ARB_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
